// File: rtl/scmp_addr_gen_if.sv
// ---------------------------------------------------------------------------
// scmp_addr_gen_if
// Command and memory-bus bundle for the SC/MP address generator.
//
// Handshakes:
//   cmd_*  : valid/ready. A command transfers on a rising clk edge where both
//            cmd_valid and cmd_ready are high. Once the master raises cmd_valid
//            it holds cmd_op/cmd_ptr/cmd_disp/cmd_wdata stable until that
//            transfer edge.
//   mem_*  : req/ack. The address generator raises mem_req with mem_addr stable
//            and holds both until it samples mem_ack high. The cycle completes
//            on that edge. mem_ack is ignored whenever mem_req is low.
//
// Modports:
//   master : sequencer / bus side (drives commands and mem_ack)
//   slave  : the address generator
// ---------------------------------------------------------------------------
interface scmp_addr_gen_if #(
    parameter int PTR_W = 16,
    parameter int SEL_W = 2
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [SEL_W-1:0] cmd_ptr;
    logic [7:0]       cmd_disp;
    logic [PTR_W-1:0] cmd_wdata;
    logic             mem_req;
    logic [PTR_W-1:0] mem_addr;
    logic             mem_ack;

    modport master (
        output cmd_valid, cmd_op, cmd_ptr, cmd_disp, cmd_wdata, mem_ack,
        input  cmd_ready, mem_req, mem_addr
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_ptr, cmd_disp, cmd_wdata, mem_ack,
        output cmd_ready, mem_req, mem_addr
    );
endinterface

// File: rtl/scmp_addr_gen.sv
// ---------------------------------------------------------------------------
// scmp_addr_gen
// SC/MP pointer file and effective-address generator. Holds NPTR pointer
// registers (P0 is the program counter), executes FETCH / EA_IDX / EA_AUTO /
// LOAD / NOP commands and drives the memory address register through a
// req/ack handshake.
//
// Optional feature macro: SCMP_AG_EXT_DISP_EN
//   defined   : cmd_disp == 8'h80 on EA_IDX/EA_AUTO uses ext_reg (E register)
//               as the displacement, sampled during CALC.
//   undefined : ext_reg is unused; 8'h80 is a plain displacement of -128.
//
// Ports:
//   clk, rst_n  clock (rising edge), asynchronous active-low reset
//   bus         scmp_addr_gen_if.slave: cmd_* valid/ready, mem_* req/ack
//   ext_reg     E register value (feature macro only)
//   done        one-cycle completion pulse
//   ea          last effective address, updated by FETCH/EA ops
//   rd_sel      pointer read select
//   rd_data     pointer[rd_sel], combinational, 0 for out-of-range index
//   state_dbg   current FSM state (0 IDLE, 1 CALC, 2 MEM, 3 DONE)
// ---------------------------------------------------------------------------
module scmp_addr_gen #(
    parameter int NPTR   = 4,
    parameter int PTR_W  = 16,
    parameter int OFFS_W = 12,
    parameter int SEL_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    scmp_addr_gen_if.slave    bus,
    input  logic [7:0]        ext_reg,
    output logic              done,
    output logic [PTR_W-1:0]  ea,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic [PTR_W-1:0]  rd_data,
    output logic [1:0]        state_dbg
);

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_FETCH = 3'd1;
    localparam logic [2:0] OP_IDX   = 3'd2;
    localparam logic [2:0] OP_AUTO  = 3'd3;
    localparam logic [2:0] OP_LOAD  = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_MEM  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [PTR_W-1:0] ptr_q [NPTR];
    logic [PTR_W-1:0] addr_q;
    logic [2:0]       op_q;
    logic [SEL_W-1:0] sel_q;
    logic [7:0]       disp_q;
    logic [PTR_W-1:0] wdata_q;

    logic [PTR_W-1:0] base;
    logic [7:0]       eff_disp;
    logic             is_mem_op;
    logic             ptr_we;
    logic [SEL_W-1:0] ptr_wsel;
    logic [PTR_W-1:0] ptr_wdata;
    logic             addr_we;
    logic [PTR_W-1:0] addr_nxt;
    logic [PTR_W-1:0] stepped;

    // Arithmetic stays inside the page: only the low OFFS_W bits move.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p,
                                                  input logic [7:0]       d);
        logic [OFFS_W-1:0] low;
        low = p[OFFS_W-1:0] + {{(OFFS_W-8){d[7]}}, d};
        return {p[PTR_W-1:OFFS_W], low};
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.cmd_valid) state_d = S_CALC;
            S_CALC: state_d = is_mem_op ? S_MEM : S_DONE;
            S_MEM:  if (bus.mem_ack) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.cmd_ready = (state_q == S_IDLE);
        bus.mem_req   = (state_q == S_MEM);
        done          = (state_q == S_DONE);
    end

    assign state_dbg    = state_q;
    assign bus.mem_addr = addr_q;

    // ---------------- Pointer reads ----------------
    // Indices at or beyond NPTR match no entry and therefore read 0.
    always_comb begin
        base    = '0;
        rd_data = '0;
        for (int i = 0; i < NPTR; i++) begin
            if (sel_q  == SEL_W'(i)) base    = ptr_q[i];
            if (rd_sel == SEL_W'(i)) rd_data = ptr_q[i];
        end
    end

`ifdef SCMP_AG_EXT_DISP_EN
    assign eff_disp = ((op_q == OP_IDX || op_q == OP_AUTO) && disp_q == 8'h80)
                      ? ext_reg : disp_q;
`else
    assign eff_disp = disp_q;
    logic unused_ext;
    assign unused_ext = ^ext_reg;
`endif

    assign is_mem_op = (op_q == OP_FETCH) || (op_q == OP_IDX) || (op_q == OP_AUTO);
    assign stepped   = wrap_add(base, eff_disp);

    // ---------------- CALC datapath ----------------
    always_comb begin
        ptr_we    = 1'b0;
        ptr_wsel  = sel_q;
        ptr_wdata = '0;
        addr_we   = 1'b0;
        addr_nxt  = addr_q;
        case (op_q)
            OP_FETCH: begin
                // Pre-increment PC; the fetch address is the new PC.
                ptr_we    = 1'b1;
                ptr_wsel  = '0;
                ptr_wdata = wrap_add(ptr_q[0], 8'h01);
                addr_we   = 1'b1;
                addr_nxt  = wrap_add(ptr_q[0], 8'h01);
            end
            OP_IDX: begin
                addr_we  = 1'b1;
                addr_nxt = stepped;
            end
            OP_AUTO: begin
                // Negative displacement pre-decrements, otherwise post-increments.
                ptr_we    = 1'b1;
                ptr_wdata = stepped;
                addr_we   = 1'b1;
                addr_nxt  = eff_disp[7] ? stepped : base;
            end
            OP_LOAD: begin
                ptr_we    = 1'b1;
                ptr_wdata = wdata_q;
            end
            default: ;
        endcase
    end

    // ---------------- Registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= OP_NOP;
            sel_q   <= '0;
            disp_q  <= '0;
            wdata_q <= '0;
        end else if (state_q == S_IDLE && bus.cmd_valid) begin
            op_q    <= bus.cmd_op;
            sel_q   <= bus.cmd_ptr;
            disp_q  <= bus.cmd_disp;
            wdata_q <= bus.cmd_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            ea     <= '0;
        end else if (state_q == S_CALC && addr_we) begin
            addr_q <= addr_nxt;
            ea     <= addr_nxt;
        end
    end

    // Writes to an index at or beyond NPTR match no entry and are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NPTR; i++) ptr_q[i] <= '0;
        end else if (state_q == S_CALC && ptr_we) begin
            for (int i = 0; i < NPTR; i++) begin
                if (ptr_wsel == SEL_W'(i)) ptr_q[i] <= ptr_wdata;
            end
        end
    end

endmodule

// File: tb/tb_scmp_addr_gen.sv
// ---------------------------------------------------------------------------
// tb_scmp_addr_gen
// Directed bench for scmp_addr_gen with hand-computed expected values.
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge, half a cycle away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_scmp_addr_gen;

    localparam int PTR_W = 16;
    localparam int SEL_W = 2;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_FETCH = 3'd1;
    localparam logic [2:0] OP_IDX   = 3'd2;
    localparam logic [2:0] OP_AUTO  = 3'd3;
    localparam logic [2:0] OP_LOAD  = 3'd4;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    scmp_addr_gen_if #(.PTR_W(PTR_W), .SEL_W(SEL_W)) bus ();

    logic [7:0]       ext_reg;
    logic             done;
    logic [PTR_W-1:0] ea;
    logic [SEL_W-1:0] rd_sel;
    logic [PTR_W-1:0] rd_data;
    logic [1:0]       state_dbg;

    scmp_addr_gen #(.NPTR(4), .PTR_W(PTR_W), .OFFS_W(12), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .ext_reg   (ext_reg),
        .done      (done),
        .ea        (ea),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [PTR_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_ptr(input string tag, input logic [SEL_W-1:0] sel,
                             input logic [PTR_W-1:0] exp);
        rd_sel = sel;
        #1;
        check(tag, rd_data, exp);
    endtask

    // ---------------- driver ----------------
    // Issues one command, answers the memory cycle after ack_wait idle cycles,
    // and reports latency (accept edge to done, in cycles) and req cycles.
    task automatic run_cmd(input logic [2:0] op, input logic [SEL_W-1:0] sel,
                           input logic [7:0] disp, input logic [PTR_W-1:0] wdata,
                           input int ack_wait, input logic is_mem,
                           input logic [PTR_W-1:0] exp_addr,
                           output int lat, output int req_cycles);
        int n;
        int w;
        logic done_seen;
        logic [PTR_W-1:0] want;
        lat        = 0;
        req_cycles = 0;
        want       = '0;
        if (is_mem) exp_q.push_back(exp_addr);
        w = 0;
        while (!bus.cmd_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        if (!bus.cmd_ready) check("ready_timeout", 0, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_ptr   = sel;
        bus.cmd_disp  = disp;
        bus.cmd_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        n = 1;
        done_seen = 1'b0;
        while (!done_seen && n < 30) begin
            if (bus.mem_req) begin
                req_cycles++;
                if (req_cycles == 1 && exp_q.size() > 0) want = exp_q.pop_front();
                check("mem_addr", bus.mem_addr, want);
                if (req_cycles == ack_wait + 1) bus.mem_ack = 1'b1;
            end
            if (done) begin
                done_seen   = 1'b1;
                lat         = n;
                bus.mem_ack = 1'b0;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        if (!done_seen) begin
            check("done_timeout", 0, 1);
            bus.mem_ack = 1'b0;
        end
        @(negedge clk);
        check("done_single", done, 0);
        check("ready_after", bus.cmd_ready, 1);
    endtask

    // ---------------- stimulus ----------------
    int lat;
    int reqc;
    logic [PTR_W-1:0] ext_exp;

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_NOP;
        bus.cmd_ptr   = '0;
        bus.cmd_disp  = '0;
        bus.cmd_wdata = '0;
        bus.mem_ack   = 1'b0;
        ext_reg       = 8'h00;
        rd_sel        = '0;

        // 1: reset, then idle
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ready", bus.cmd_ready, 1);
        check("rst_req", bus.mem_req, 0);
        check("rst_done", done, 0);
        check("rst_ea", ea, 0);
        check("rst_state", state_dbg, 0);
        for (int i = 0; i < 4; i++) check_ptr("rst_ptr", SEL_W'(i), 16'h0000);

        // 2: PC fetch with page wrap
        run_cmd(OP_LOAD, 2'd0, 8'h00, 16'h1FFE, 0, 1'b0, 16'h0, lat, reqc);
        check("load_lat", lat, 2);
        check("load_noreq", reqc, 0);
        check_ptr("p0_load", 2'd0, 16'h1FFE);
        run_cmd(OP_FETCH, 2'd3, 8'h00, 16'h0, 0, 1'b1, 16'h1FFF, lat, reqc);
        check("fetch_lat", lat, 3);
        check("fetch_req", reqc, 1);
        check("fetch1_ea", ea, 16'h1FFF);
        run_cmd(OP_FETCH, 2'd0, 8'h00, 16'h0, 0, 1'b1, 16'h1000, lat, reqc);
        check("fetch2_ea", ea, 16'h1000);
        check_ptr("p0_wrap", 2'd0, 16'h1000);

        // 3: indexed, negative displacement with borrow kept inside the page
        run_cmd(OP_LOAD, 2'd2, 8'h00, 16'h2005, 0, 1'b0, 16'h0, lat, reqc);
        run_cmd(OP_IDX, 2'd2, 8'hF0, 16'h0, 0, 1'b1, 16'h2FF5, lat, reqc);
        check("idx_ea", ea, 16'h2FF5);
        check_ptr("p2_kept", 2'd2, 16'h2005);

        // 4: auto-indexed pre-decrement then post-increment
        run_cmd(OP_LOAD, 2'd1, 8'h00, 16'h3010, 0, 1'b0, 16'h0, lat, reqc);
        run_cmd(OP_AUTO, 2'd1, 8'hFC, 16'h0, 0, 1'b1, 16'h300C, lat, reqc);
        check_ptr("p1_predec", 2'd1, 16'h300C);
        run_cmd(OP_AUTO, 2'd1, 8'h04, 16'h0, 0, 1'b1, 16'h300C, lat, reqc);
        check("auto_ea", ea, 16'h300C);
        check_ptr("p1_postinc", 2'd1, 16'h3010);

        // NOP and reserved op: no memory cycle, no state change
        run_cmd(OP_NOP, 2'd1, 8'h00, 16'hFFFF, 0, 1'b0, 16'h0, lat, reqc);
        check("nop_lat", lat, 2);
        run_cmd(3'd7, 2'd1, 8'h00, 16'hFFFF, 0, 1'b0, 16'h0, lat, reqc);
        check("op7_noreq", reqc, 0);
        check_ptr("p1_after_nop", 2'd1, 16'h3010);
        check("nop_ea", ea, 16'h300C);

        // 5: delayed ack, then stray ack in idle
        run_cmd(OP_IDX, 2'd1, 8'h00, 16'h0, 3, 1'b1, 16'h3010, lat, reqc);
        check("wait_req_cycles", reqc, 4);
        check("wait_lat", lat, 6);
        bus.mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stray_req", bus.mem_req, 0);
            check("stray_done", done, 0);
            check("stray_state", state_dbg, 0);
        end
        bus.mem_ack = 1'b0;

        // 6: E-register displacement (or plain -128 without the feature)
`ifdef SCMP_AG_EXT_DISP_EN
        ext_exp = 16'h4005;
`else
        ext_exp = 16'h4F80;
`endif
        ext_reg = 8'h05;
        run_cmd(OP_LOAD, 2'd3, 8'h00, 16'h4000, 0, 1'b0, 16'h0, lat, reqc);
        run_cmd(OP_IDX, 2'd3, 8'h80, 16'h0, 0, 1'b1, ext_exp, lat, reqc);
        check("disp80_ea", ea, ext_exp);

        // 6: reset while in MEM
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_IDX;
        bus.cmd_ptr   = 2'd2;
        bus.cmd_disp  = 8'h01;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_req", bus.mem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_req", bus.mem_req, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_addr", bus.mem_addr, 0);
        check("rst_mid_ea", ea, 0);
        for (int i = 0; i < 4; i++) check_ptr("rst_mid_ptr", SEL_W'(i), 16'h0000);
        bus.mem_ack = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("late_ack_done", done, 0);
            check("late_ack_state", state_dbg, 0);
        end
        bus.mem_ack = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
